inst_fetch_if: RTL and testbench

Instruction-fetch bus interface and IF/ID pipeline register. Sits directly downstream of the PC generator: it takes the current PC and chip-enable, runs a request/acknowledge transaction on the instruction memory port, and registers the fetched `{pc, inst}` pair for the decode stage. It asserts a stall request while a fetch is outstanding, and honours the pipeline stall vector and the exception flush.

---
 rtl/inst_fetch_if.sv | 125 ++++++++++++
 tb/tb_inst_fetch_if.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
// Instruction-fetch bus interface and IF/ID pipeline register.
// Issues one memory request per fetch, parks early data under stall, and feeds decode.
module inst_fetch_if #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        stallreq_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        deliver;
  logic [31:0] deliver_pc;
  logic [31:0] deliver_inst;
  logic        unused_stall;

  assign unused_stall = ^{stall[5:3], stall[0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= 32'h0;
      hold_pc    <= 32'h0;
      hold_inst  <= 32'h0;
    end else if (flush) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      hold_pc    <= 32'h0;
      hold_inst  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (ce_i) begin
            mem_addr_o <= pc_i;
            mem_req_o  <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // A completed transfer is never dropped: if IF is stalled it is parked.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            if (stall[1]) begin
              hold_pc   <= mem_addr_o;
              hold_inst <= mem_rdata_i;
              state     <= HOLD;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (!stall[1]) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    deliver      = 1'b0;
    deliver_pc   = hold_pc;
    deliver_inst = hold_inst;
    if (!flush && !stall[1]) begin
      if (state == BUSY && mem_ack_i) begin
        deliver      = 1'b1;
        deliver_pc   = mem_addr_o;
        deliver_inst = mem_rdata_i;
      end else if (state == HOLD) begin
        deliver = 1'b1;
      end
    end
  end

  // IF stalled while ID runs inserts a bubble; both stalled freezes IF/ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc_o   <= RESET_PC;
      id_inst_o <= 32'h0;
    end else if (flush || (stall[1] && !stall[2])) begin
      id_pc_o   <= RESET_PC;
      id_inst_o <= 32'h0;
    end else if (!stall[1]) begin
      if (deliver) begin
        id_pc_o   <= deliver_pc;
        id_inst_o <= deliver_inst;
      end else begin
        id_pc_o   <= RESET_PC;
        id_inst_o <= 32'h0;
      end
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    if (!flush) begin
      case (state)
        IDLE:    stallreq_o = ce_i;
        BUSY:    stallreq_o = ~mem_ack_i;
        default: stallreq_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_if.sv
// Self-checking bench for inst_fetch_if: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_inst_fetch_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic        ce_i = 1'b0;
  logic [5:0]  stall = 6'h0;
  logic        flush = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        stallreq_o;

  int checks = 0;
  int passes = 0;
  logic last_sr;

  inst_fetch_if #(.RESET_PC(32'h00000000)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .stall(stall), .flush(flush),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else
      passes++;
  endtask

  // Called at posedge+1: drives inputs, samples stallreq, then advances one clock.
  task automatic applyStimulus(input logic ce, input logic [31:0] pc, input logic [5:0] stl,
                               input logic fl, input logic ack, input logic [31:0] rdata);
    ce_i = ce; pc_i = pc; stall = stl; flush = fl; mem_ack_i = ack; mem_rdata_i = rdata;
    #1 last_sr = stallreq_o;
    @(posedge clk);
    #1;
  endtask

  // Transaction model: an outstanding request, a parked word, and the IF/ID pair.
  logic        m_pend = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic        m_park = 1'b0;
  logic [31:0] m_ppc = 32'h0, m_pinst = 32'h0;
  logic [31:0] m_idpc = 32'h0, m_idinst = 32'h0;

  always @(negedge clk) begin
    logic        have, delivered, exp_sr;
    logic [31:0] hpc, hinst;
    if (!rst) begin
      m_pend = 0; m_park = 0; m_idpc = 0; m_idinst = 0;
    end
    exp_sr = flush ? 1'b0 : m_pend ? !mem_ack_i : m_park ? 1'b0 : ce_i;
    checkOutput("model id_pc", id_pc_o, m_idpc);
    checkOutput("model id_inst", id_inst_o, m_idinst);
    checkOutput("model mem_req", {31'h0, mem_req_o}, {31'h0, m_pend});
    checkOutput("model stallreq", {31'h0, stallreq_o}, {31'h0, exp_sr});
    if (m_pend) checkOutput("model mem_addr", mem_addr_o, m_addr);
    if (rst) begin
      have = 0; delivered = 0; hpc = 0; hinst = 0;
      if (m_pend && mem_ack_i) begin
        have = 1; hpc = m_addr; hinst = mem_rdata_i;
      end else if (m_park) begin
        have = 1; hpc = m_ppc; hinst = m_pinst;
      end
      if (flush) begin
        m_pend = 0; m_park = 0; m_idpc = 0; m_idinst = 0;
      end else begin
        if (have) begin
          m_pend = 0;
          if (stall[1]) begin
            m_park = 1; m_ppc = hpc; m_pinst = hinst;
          end else begin
            m_park = 0; delivered = 1;
          end
        end else if (!m_pend && ce_i) begin
          m_pend = 1; m_addr = pc_i;
        end
        if (stall[1] && !stall[2]) begin
          m_idpc = 0; m_idinst = 0;
        end else if (!stall[1]) begin
          m_idpc = delivered ? hpc : 32'h0;
          m_idinst = delivered ? hinst : 32'h0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    checkOutput("reset id_inst", id_inst_o, 32'h0);
    checkOutput("reset id_pc", id_pc_o, 32'h0);
    checkOutput("reset mem_req", {31'h0, mem_req_o}, 32'h0);
    checkOutput("reset mem_addr", mem_addr_o, 32'h0);
    checkOutput("reset stallreq", {31'h0, stallreq_o}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Zero-wait fetch of address 0
    applyStimulus(1, 32'h0, 6'h0, 0, 0, 32'h0);
    checkOutput("t1 stallreq issue", {31'h0, last_sr}, 32'h1);
    checkOutput("t1 req", {31'h0, mem_req_o}, 32'h1);
    checkOutput("t1 addr", mem_addr_o, 32'h0);
    applyStimulus(0, 32'h0, 6'h0, 0, 1, 32'h34010001);
    checkOutput("t1 stallreq ack", {31'h0, last_sr}, 32'h0);
    checkOutput("t1 id_inst", id_inst_o, 32'h34010001);
    checkOutput("t1 id_pc", id_pc_o, 32'h0);
    checkOutput("t1 req drop", {31'h0, mem_req_o}, 32'h0);

    // Three wait states at 0x100; pc_i changes must not disturb the address
    applyStimulus(1, 32'h100, 6'h0, 0, 0, 32'h0);
    checkOutput("t2 stallreq issue", {31'h0, last_sr}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'hFFFF0000, 6'h0, 0, 0, 32'h0);
      checkOutput("t2 stallreq wait", {31'h0, last_sr}, 32'h1);
      checkOutput("t2 addr held", mem_addr_o, 32'h100);
      checkOutput("t2 bubble", id_inst_o, 32'h0);
    end
    applyStimulus(0, 32'hFFFF0000, 6'h0, 0, 1, 32'h8C220004);
    checkOutput("t2 stallreq ack", {31'h0, last_sr}, 32'h0);
    checkOutput("t2 id_inst", id_inst_o, 32'h8C220004);
    checkOutput("t2 id_pc", id_pc_o, 32'h100);

    // Ack under stall parks the word until IF is released
    applyStimulus(1, 32'h40, 6'h0, 0, 0, 32'h0);
    applyStimulus(1, 32'h80, 6'b000111, 0, 1, 32'h11112222);
    checkOutput("t3 req after park", {31'h0, mem_req_o}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 32'h80, 6'b000111, 0, 0, 32'h0);
      checkOutput("t3 no reissue", {31'h0, mem_req_o}, 32'h0);
      checkOutput("t3 stallreq hold", {31'h0, last_sr}, 32'h0);
      checkOutput("t3 id held", id_inst_o, 32'h0);
    end
    applyStimulus(0, 32'h80, 6'h0, 0, 0, 32'h0);
    checkOutput("t3 release inst", id_inst_o, 32'h11112222);
    checkOutput("t3 release pc", id_pc_o, 32'h40);

    // Flush during BUSY at 0x200 with a coincident ack
    applyStimulus(1, 32'h200, 6'h0, 0, 0, 32'h0);
    applyStimulus(0, 32'h200, 6'h0, 0, 0, 32'h0);
    applyStimulus(0, 32'h20, 6'h0, 1, 1, 32'hBAD0BAD0);
    checkOutput("t4 stallreq flush", {31'h0, last_sr}, 32'h0);
    checkOutput("t4 req drop", {31'h0, mem_req_o}, 32'h0);
    checkOutput("t4 id bubble", id_inst_o, 32'h0);
    applyStimulus(1, 32'h20, 6'h0, 0, 1, 32'hBAD0BAD0);
    checkOutput("t4 late ack ignored", id_inst_o, 32'h0);
    checkOutput("t4 new addr", mem_addr_o, 32'h20);
    applyStimulus(0, 32'h20, 6'h0, 0, 1, 32'h00000055);
    checkOutput("t4 new inst", id_inst_o, 32'h00000055);
    checkOutput("t4 new pc", id_pc_o, 32'h20);

    // IF stalled, ID free, nothing pending: bubbles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'h0, 6'b000011, 0, 0, 32'h0);
      checkOutput("t6 bubble inst", id_inst_o, 32'h0);
      checkOutput("t6 bubble pc", id_pc_o, 32'h0);
    end

    // Asynchronous reset in the middle of a BUSY cycle
    applyStimulus(1, 32'h300, 6'h0, 0, 0, 32'h0);
    checkOutput("t5 busy req", {31'h0, mem_req_o}, 32'h1);
    ce_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("t5 async req", {31'h0, mem_req_o}, 32'h0);
    checkOutput("t5 async inst", id_inst_o, 32'h0);
    checkOutput("t5 async addr", mem_addr_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(1, 32'h304, 6'h0, 0, 0, 32'h0);
    checkOutput("t5 restart stallreq", {31'h0, last_sr}, 32'h1);
    checkOutput("t5 restart addr", mem_addr_o, 32'h304);
    applyStimulus(0, 32'h304, 6'h0, 0, 1, 32'h2002000A);
    checkOutput("t5 restart inst", id_inst_o, 32'h2002000A);
    checkOutput("t5 restart pc", id_pc_o, 32'h304);

    // Back-to-back zero-wait fetches, always-ack memory
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 32'h400 + 32'(4 * i), 6'h0, 0, 1, 32'hA5000000 + 32'(i));
    applyStimulus(0, 32'h0, 6'h0, 0, 0, 32'h0);
    applyStimulus(0, 32'h0, 6'h0, 0, 0, 32'h0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
